dfd_tn_wrr_sched: RTL and testbench
===================================

Name: dfd_tn_wrr_sched

Overview:
Weighted round-robin scheduler that shares one trace-network output slot between NUM_SRC packet sources (DST, NTR, and future sources).
- Sits between the source funnels and the trace network, in place of a fixed two-way alternator.
- Each source gets up to its programmed weight of back-to-back pulls per burst.
- Flushing sources get strict priority.
- Backpressure is honoured per source.

Parameters:
- NUM_SRC, 4, number of packet sources (≥2).
- DATA_WIDTH_IN_BYTES, TNIF_DATA_OUT_WIDTH_IN_BYTES, width of each source's data.
- WEIGHT_W, 4, bits per source weight.
- STARVE_LIMIT, 64, grant cycles before starvation pre-emption (optional feature only).

Ports:
- clock, input, 1, clock.
- reset, input, 1, asynchronous active-high reset.
- cfg_en_in, input, 1, scheduler enable.
- src_weight_in, input, NUM_SRC*WEIGHT_W, per-source burst weight; 0 is treated as 1.
- src_req_in, input, NUM_SRC, source has a packet.
- src_data_in, input, NUM_SRC*DATA_WIDTH_IN_BYTES*8, source packet data.
- src_bp_in, input, NUM_SRC, network backpressure per source.
- src_flush_in, input, NUM_SRC, network flush per source.
- tr_gnt_in, input, 1, network accepts a beat this cycle.
- src_pull_out, output, NUM_SRC, one-hot pop to the granted source.
- tr_valid_out, output, 1, beat valid.
- tr_src_out, output, $clog2(NUM_SRC), index of the granted source.
- tr_data_out, output, DATA_WIDTH_IN_BYTES*8, muxed data.
- busy_out, output, 1, FSM not in IDLE.
- starve_err_out, output, 1, sticky starvation flag.

Behaviour:
- elig[i] = src_req_in[i] & ~(src_bp_in[i] & ~src_flush_in[i]); fl[i] = src_req_in[i] & src_flush_in[i].
- Outputs are combinational from the current state and inputs, so a pull happens in the same cycle as the grant (zero latency). State updates only on clock edges.
- tr_valid_out = |src_pull_out. tr_src_out and tr_data_out select the pulled source. When nothing is pulled, tr_src_out=0 and tr_data_out=0.
- src_pull_out is one-hot or zero. It is zero whenever tr_gnt_in=0 or cfg_en_in=0.
- Registers: state, owner, last_owner, burst_cnt (WEIGHT_W bits), burst_wt (latched weight).
- Reset values: state=IDLE, owner=0, last_owner=NUM_SRC-1, burst_cnt=0, burst_wt=0, starve_err_out=0. All outputs read 0 during and right after reset.
- FSM states:
  - IDLE: if tr_gnt_in & |elig & no fl: pick the first elig index searching from last_owner+1 with wrap. Pull it, set owner, latch burst_wt from its weight, set burst_cnt=1. Go to BURST, or stay in IDLE with last_owner=pick if burst_wt==1.
  - BURST: if tr_gnt_in & elig[owner]: pull owner, burst_cnt++. When the incremented count equals burst_wt, go to IDLE and set last_owner=owner.
  - BURST, owner lost eligibility: if tr_gnt_in & ~elig[owner] & |elig, abandon the burst. Set last_owner=owner and start a new burst from the RR pick in the same cycle (no bubble).
  - BURST, nothing eligible: if no source is eligible, return to IDLE with last_owner=owner.
  - BURST, tr_gnt_in=0: hold all state.
  - FLUSH: entered from any state when |fl. Serve the lowest index with fl set, one pull per tr_gnt_in; weights are ignored. Exit to IDLE when no fl remains. last_owner is unchanged and any interrupted burst is discarded.
  - FLUSH wins over all other transitions in the same cycle.
- Weight changes mid-burst have no effect; weight is latched at burst start.
- cfg_en_in=0: synchronously return to IDLE and hold there. last_owner is kept; burst_cnt=0.
- Reset asserted mid-burst: all state clears immediately (asynchronous); no pull in that cycle.
- burst_cnt never wraps; the maximum weight is 2^WEIGHT_W-1.
- Assertions:
  - src_pull_out one-hot-or-zero.
  - src_pull_out[i] implies src_req_in[i].
  - No pull when tr_gnt_in=0.

Optional Feature:
DFD_TN_SCHED_STARVE_EN
- With the macro:
  - A per-source counter increments on every tr_gnt_in cycle where elig[i] & ~src_pull_out[i]. It clears on a pull or when elig[i] drops, and saturates at STARVE_LIMIT.
  - When any counter reaches STARVE_LIMIT, the lowest such index pre-empts on the next grant (outside FLUSH). It starts a fresh burst and sets starve_err_out.
  - starve_err_out is sticky until reset.
- Without the macro: no counters; starve_err_out is tied 0.

Decomposition:
- dfd_tn_pkg:
  - tnSchedState_e {IDLE, BURST, FLUSH}.
  - TN_SCHED_DEFAULT_WEIGHT=1.
- Sub-module dfd_tn_rr_pick:
  - Parameter NUM_SRC; inputs req vector and last pointer.
  - Outputs: found, index, one-hot.
  - Purely combinational rotate-and-priority-encode. Instantiated once for the RR pick; the flush pick uses a fixed priority encoder.

Test Plan:
- NUM_SRC=4, weights {1,2,3,1}, all req=1, gnt=1, no bp: pull order 0,1,1,2,2,2,3,0,…; period 7 cycles; no bubbles.
- Source 1 mid-burst (weight 3, 1 beat sent) raises bp: same cycle pull moves to 2; later src 1 resumes with a fresh burst of 3.
- src_flush_in[2]=1 and src_bp_in[2]=1 while src 0 bursting: src 2 pulled next gnt despite bp; weights ignored; on flush drop FSM→IDLE, RR resumes from 1.
- tr_gnt_in toggles 1,0,1,0 during a weight-3 burst of src 0: 3 pulls over 5 cycles; no pull on gnt=0 cycles; state held.
- Assert reset during BURST then release with all req=1: first pull is src 0; busy_out=0 in reset; all outputs 0.
- With DFD_TN_SCHED_STARVE_EN, STARVE_LIMIT=4, src 3 eligible but weights {15,15,15,1}: src 3 pre-empts after 4 unserved grants; starve_err_out=1 and stays set.

Source files
------------

// File: rtl/dfd_tn_pkg.sv
// ============================================================================
// dfd_tn_pkg : shared types and constants for the trace-network WRR scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

package dfd_tn_pkg;

  localparam int TNIF_DATA_OUT_WIDTH_IN_BYTES = 8;
  localparam int TN_SCHED_DEFAULT_WEIGHT      = 1;

  localparam logic [1:0] TN_ST_IDLE  = 2'd0;
  localparam logic [1:0] TN_ST_BURST = 2'd1;
  localparam logic [1:0] TN_ST_FLUSH = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = TN_ST_IDLE,
    BURST = TN_ST_BURST,
    FLUSH = TN_ST_FLUSH
  } tnSchedState_e;

endpackage

`default_nettype wire

// File: rtl/dfd_tn_rr_pick.sv
// ============================================================================
// dfd_tn_rr_pick : round-robin pick, first request searching from last_i+1
// Rev 1.0
// ============================================================================
`default_nettype none

module dfd_tn_rr_pick #(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]         req_i,
  input  logic [$clog2(NUM_SRC)-1:0] last_i,
  output logic                       found_o,
  output logic [$clog2(NUM_SRC)-1:0] idx_o,
  output logic [NUM_SRC-1:0]         onehot_o
);

  localparam int IDX_W = $clog2(NUM_SRC);

  int c;

  // Offsets 1..NUM_SRC visit every source once, ending on last_i itself.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    c       = 0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      c = (int'(last_i) + k) % NUM_SRC;
      if (!found_o && req_i[c]) begin
        found_o = 1'b1;
        idx_o   = c[IDX_W-1:0];
      end
    end
  end

  assign onehot_o = found_o ? (NUM_SRC'(1) << idx_o) : '0;

endmodule

`default_nettype wire

// File: rtl/dfd_tn_wrr_sched.sv
// ============================================================================
// dfd_tn_wrr_sched : weighted round-robin trace-network slot scheduler
// Optional DFD_TN_SCHED_STARVE_EN adds starvation pre-emption.  Rev 1.0
// ============================================================================
`default_nettype none

module dfd_tn_wrr_sched
  import dfd_tn_pkg::*;
#(
  parameter int NUM_SRC             = 4,
  parameter int DATA_WIDTH_IN_BYTES = TNIF_DATA_OUT_WIDTH_IN_BYTES,
  parameter int WEIGHT_W            = 4,
  parameter int STARVE_LIMIT        = 64
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 cfg_en_in,
  input  logic [NUM_SRC*WEIGHT_W-1:0]          src_weight_in,
  input  logic [NUM_SRC-1:0]                   src_req_in,
  input  logic [NUM_SRC*DATA_WIDTH_IN_BYTES*8-1:0] src_data_in,
  input  logic [NUM_SRC-1:0]                   src_bp_in,
  input  logic [NUM_SRC-1:0]                   src_flush_in,
  input  logic                                 tr_gnt_in,
  output logic [NUM_SRC-1:0]                   src_pull_out,
  output logic                                 tr_valid_out,
  output logic [$clog2(NUM_SRC)-1:0]           tr_src_out,
  output logic [DATA_WIDTH_IN_BYTES*8-1:0]     tr_data_out,
  output logic                                 busy_out,
  output logic                                 starve_err_out
);

  localparam int IDX_W = $clog2(NUM_SRC);
  localparam int DW    = DATA_WIDTH_IN_BYTES * 8;

  tnSchedState_e        state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     last_owner_q, last_owner_d;
  logic [WEIGHT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic [WEIGHT_W-1:0]  burst_wt_q, burst_wt_d;

  logic [NUM_SRC-1:0]   elig, fl;
  logic                 any_elig;
  logic                 fl_found;
  logic [IDX_W-1:0]     fl_idx;
  logic [WEIGHT_W-1:0]  eff_wt [NUM_SRC];
  logic [WEIGHT_W-1:0]  cnt_inc;

  logic                 rr_found;
  logic [IDX_W-1:0]     rr_idx, rr_last;
  logic [NUM_SRC-1:0]   rr_oh;

  logic                 pull_v;
  logic [IDX_W-1:0]     pull_idx;
  logic                 do_start;
  logic [IDX_W-1:0]     start_idx;

  // Flushing sources ignore backpressure so the network can drain them.
  assign elig     = src_req_in & ~(src_bp_in & ~src_flush_in);
  assign fl       = src_req_in & src_flush_in;
  assign any_elig = |elig;
  assign cnt_inc  = burst_cnt_q + WEIGHT_W'(1);

  always_comb begin
    fl_found = 1'b0;
    fl_idx   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (fl[i]) begin
        fl_found = 1'b1;
        fl_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      eff_wt[i] = src_weight_in[i*WEIGHT_W +: WEIGHT_W];
      if (eff_wt[i] == '0) eff_wt[i] = WEIGHT_W'(TN_SCHED_DEFAULT_WEIGHT);
    end
  end

  // While bursting, an abandoned owner hands over to the source after it.
  assign rr_last = (state_q == BURST) ? owner_q : last_owner_q;

  dfd_tn_rr_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_rr_pick (
    .req_i    (elig),
    .last_i   (rr_last),
    .found_o  (rr_found),
    .idx_o    (rr_idx),
    .onehot_o (rr_oh)
  );

`ifdef DFD_TN_SCHED_STARVE_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);

  logic [SC_W-1:0]    starve_cnt_q [NUM_SRC];
  logic               st_found;
  logic [IDX_W-1:0]   st_idx;
  logic               starve_take;
  logic               starve_err_q;

  always_comb begin
    st_found = 1'b0;
    st_idx   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (starve_cnt_q[i] == SC_W'(STARVE_LIMIT)) begin
        st_found = 1'b1;
        st_idx   = IDX_W'(i);
      end
    end
  end

  assign starve_take = cfg_en_in & ~fl_found & (state_q != FLUSH) & tr_gnt_in & st_found;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SRC; i++) starve_cnt_q[i] <= '0;
      starve_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (!elig[i] || src_pull_out[i]) begin
          starve_cnt_q[i] <= '0;
        end else if (tr_gnt_in && (starve_cnt_q[i] != SC_W'(STARVE_LIMIT))) begin
          starve_cnt_q[i] <= starve_cnt_q[i] + SC_W'(1);
        end
      end
      if (starve_take) starve_err_q <= 1'b1;
    end
  end

  assign starve_err_out = starve_err_q;
`else
  assign starve_err_out = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    burst_wt_d   = burst_wt_q;
    pull_v       = 1'b0;
    pull_idx     = '0;
    do_start     = 1'b0;
    start_idx    = '0;

    if (!cfg_en_in) begin
      state_d     = IDLE;
      burst_cnt_d = '0;
    end else if (fl_found) begin
      state_d     = FLUSH;
      burst_cnt_d = '0;
      if (tr_gnt_in) begin
        pull_v   = 1'b1;
        pull_idx = fl_idx;
      end
    end else if (state_q == FLUSH) begin
      state_d = IDLE;
`ifdef DFD_TN_SCHED_STARVE_EN
    end else if (starve_take) begin
      do_start  = 1'b1;
      start_idx = st_idx;
`endif
    end else if (state_q == IDLE) begin
      if (tr_gnt_in && rr_found) begin
        do_start  = 1'b1;
        start_idx = rr_idx;
      end
    end else if (!any_elig) begin
      state_d      = IDLE;
      last_owner_d = owner_q;
      burst_cnt_d  = '0;
    end else if (tr_gnt_in) begin
      if (elig[owner_q]) begin
        pull_v      = 1'b1;
        pull_idx    = owner_q;
        burst_cnt_d = cnt_inc;
        if (cnt_inc == burst_wt_q) begin
          state_d      = IDLE;
          last_owner_d = owner_q;
          burst_cnt_d  = '0;
        end
      end else begin
        last_owner_d = owner_q;
        do_start     = 1'b1;
        start_idx    = rr_idx;
      end
    end

    // A single-beat burst completes immediately and never leaves IDLE.
    if (do_start) begin
      pull_v      = 1'b1;
      pull_idx    = start_idx;
      owner_d     = start_idx;
      burst_wt_d  = eff_wt[start_idx];
      burst_cnt_d = WEIGHT_W'(1);
      if (eff_wt[start_idx] == WEIGHT_W'(1)) begin
        state_d      = IDLE;
        last_owner_d = start_idx;
      end else begin
        state_d = BURST;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= IDX_W'(NUM_SRC - 1);
      burst_cnt_q  <= '0;
      burst_wt_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      burst_wt_q   <= burst_wt_d;
    end
  end

  assign src_pull_out = (pull_v && !reset) ? (NUM_SRC'(1) << pull_idx) : '0;
  assign tr_valid_out = |src_pull_out;
  assign tr_src_out   = tr_valid_out ? pull_idx : '0;
  assign tr_data_out  = tr_valid_out ? src_data_in[int'(pull_idx)*DW +: DW] : '0;
  assign busy_out     = (state_q != IDLE);

  a_pull_onehot: assert property (@(posedge clock) disable iff (reset)
    $onehot0(src_pull_out));
  a_pull_has_req: assert property (@(posedge clock) disable iff (reset)
    (src_pull_out & ~src_req_in) == '0);
  a_no_pull_wo_gnt: assert property (@(posedge clock) disable iff (reset)
    !tr_gnt_in |-> (src_pull_out == '0));

  // rr_oh is kept on the picker for other users; this block steers by index.
  logic unused_rr_oh;
  assign unused_rr_oh = ^rr_oh;

endmodule

`default_nettype wire

// File: tb/tb_dfd_tn_wrr_sched.sv
// ============================================================================
// tb_dfd_tn_wrr_sched : directed-vector bench for the WRR trace scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dfd_tn_wrr_sched;

  localparam int N = 4;

  logic         clock;
  logic         reset;
  logic         cfg_en_in;
  logic [15:0]  src_weight_in;
  logic [3:0]   src_req_in;
  logic [31:0]  src_data_in;
  logic [3:0]   src_bp_in;
  logic [3:0]   src_flush_in;
  logic         tr_gnt_in;
  logic [3:0]   src_pull_out;
  logic         tr_valid_out;
  logic [1:0]   tr_src_out;
  logic [7:0]   tr_data_out;
  logic         busy_out;
  logic         starve_err_out;

  int n_tests = 0;
  int n_fail  = 0;

  dfd_tn_wrr_sched #(
    .NUM_SRC             (N),
    .DATA_WIDTH_IN_BYTES (1),
    .WEIGHT_W            (4),
    .STARVE_LIMIT        (4)
  ) u_dut (
    .clock          (clock),
    .reset          (reset),
    .cfg_en_in      (cfg_en_in),
    .src_weight_in  (src_weight_in),
    .src_req_in     (src_req_in),
    .src_data_in    (src_data_in),
    .src_bp_in      (src_bp_in),
    .src_flush_in   (src_flush_in),
    .tr_gnt_in      (tr_gnt_in),
    .src_pull_out   (src_pull_out),
    .tr_valid_out   (tr_valid_out),
    .tr_src_out     (tr_src_out),
    .tr_data_out    (tr_data_out),
    .busy_out       (busy_out),
    .starve_err_out (starve_err_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // e < 0 means no pull expected this cycle.
  task automatic exp_pull(input string tag, input int e);
    logic [3:0] oh;
    logic [1:0] ix;
    logic [7:0] dat;
    oh  = (e < 0) ? 4'b0000 : (4'b0001 << e);
    ix  = (e < 0) ? 2'd0 : 2'(e);
    dat = (e < 0) ? 8'h00 : 8'(8'hA0 + 8'h11 * e);
    chk({tag, "_pull"}, 32'(src_pull_out), 32'(oh));
    chk({tag, "_valid"}, 32'(tr_valid_out), (e < 0) ? 32'd0 : 32'd1);
    chk({tag, "_src"}, 32'(tr_src_out), 32'(ix));
    chk({tag, "_data"}, 32'(tr_data_out), 32'(dat));
  endtask

  task automatic next();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    next();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int seq1 [14] = '{0, 1, 1, 2, 2, 2, 3, 0, 1, 1, 2, 2, 2, 3};
  int seq2 [9]  = '{1, 2, 2, 3, 0, 1, 1, 1, 2};
  int gnt4 [13] = '{1, 0, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
  int cfg4 [13] = '{1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1};
  int exp4 [13] = '{0, -1, 0, -1, 0, 1, -1, -1, 1, 1, 2, 3, 0};

  initial begin
    clock         = 1'b0;
    reset         = 1'b1;
    cfg_en_in     = 1'b1;
    src_weight_in = {4'd1, 4'd3, 4'd2, 4'd1};
    src_req_in    = 4'b1111;
    src_data_in   = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    src_bp_in     = 4'b0000;
    src_flush_in  = 4'b0000;
    tr_gnt_in     = 1'b1;

    // Outputs held at zero while in reset even with requests and grant up.
    #2;
    exp_pull("in_reset", -1);
    chk("in_reset_busy", 32'(busy_out), 0);
    chk("in_reset_starve", 32'(starve_err_out), 0);
    next();
    next();
    reset = 1'b0;

    // Weights {1,2,3,1}: period-7 pattern with no bubbles.
    for (int k = 0; k < 14; k++) begin
      if (k > 0) next();
      #1;
      exp_pull($sformatf("rr%0d", k), seq1[k]);
      if (k == 0) chk("rr0_busy", 32'(busy_out), 0);
      if (k == 2) chk("rr2_busy", 32'(busy_out), 1);
    end

    // Reset asserted while source 1 is mid-burst.
    next(); #1; exp_pull("pre_rst0", 0);
    next(); #1; exp_pull("pre_rst1", 1);
    next(); #1; exp_pull("pre_rst2", 1);
    chk("pre_rst_busy", 32'(busy_out), 1);
    reset = 1'b1;
    #1;
    exp_pull("mid_rst", -1);
    chk("mid_rst_busy", 32'(busy_out), 0);
    src_weight_in = {4'd1, 4'd2, 4'd3, 4'd1};
    next();
    reset = 1'b0;
    #1;
    exp_pull("post_rst", 0);

    // Source 1 (weight 3) loses eligibility after one beat.
    for (int k = 0; k < 9; k++) begin
      next();
      if (k == 1) src_bp_in = 4'b0010;
      if (k == 3) src_bp_in = 4'b0000;
      #1;
      exp_pull($sformatf("bp%0d", k), seq2[k]);
    end

    // Flush of source 2 pre-empts a source-0 burst despite backpressure.
    src_req_in    = 4'b0001;
    src_weight_in = {4'd1, 4'd1, 4'd1, 4'd2};
    do_reset();
    #1; exp_pull("fl_a", 0);
    next(); #1; exp_pull("fl_b", 0);
    next(); #1; exp_pull("fl_c", 0);
    next();
    src_req_in   = 4'b1111;
    src_flush_in = 4'b0100;
    src_bp_in    = 4'b0100;
    #1;
    exp_pull("fl_d", 2);
    chk("fl_d_busy", 32'(busy_out), 1);
    next(); #1; exp_pull("fl_e", 2);
    chk("fl_e_busy", 32'(busy_out), 1);
    next();
    src_flush_in = 4'b0000;
    src_bp_in    = 4'b0000;
    #1;
    begin
      int waited;
      waited = 0;
      while (!tr_valid_out && waited < 4) begin
        next();
        #1;
        waited++;
      end
      chk("fl_resume_valid", 32'(tr_valid_out), 1);
      chk("fl_resume_src", 32'(tr_src_out), 1);
    end

    // Grant toggling, enable drop, and a zero weight treated as one.
    src_weight_in = {4'd1, 4'd0, 4'd2, 4'd3};
    do_reset();
    for (int k = 0; k < 13; k++) begin
      if (k > 0) next();
      tr_gnt_in = gnt4[k][0];
      cfg_en_in = cfg4[k][0];
      #1;
      exp_pull($sformatf("gc%0d", k), exp4[k]);
      if (k == 1) chk("gc1_busy", 32'(busy_out), 1);
      if (k == 7) chk("gc7_busy", 32'(busy_out), 0);
      if (k == 11) chk("gc11_busy", 32'(busy_out), 0);
    end

`ifdef DFD_TN_SCHED_STARVE_EN
    // Source 3 starves behind a weight-15 burst and pre-empts after 4 grants.
    tr_gnt_in     = 1'b1;
    cfg_en_in     = 1'b1;
    src_req_in    = 4'b1001;
    src_weight_in = {4'd1, 4'd15, 4'd15, 4'd15};
    do_reset();
    for (int k = 0; k < 7; k++) begin
      if (k > 0) next();
      #1;
      exp_pull($sformatf("sv%0d", k), (k == 4) ? 3 : 0);
      chk($sformatf("sv%0d_err", k), 32'(starve_err_out), (k >= 5) ? 32'd1 : 32'd0);
    end
    src_req_in = 4'b0000;
    next(); next(); #1;
    chk("sv_sticky", 32'(starve_err_out), 1);
`else
    next(); #1;
    chk("starve_off", 32'(starve_err_out), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
